hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state rises on posedge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have ports rs1_D and rs2_D, input, REG_AW, meaning decode-stage source registers.
REQ-006 SHALL have ports rs1_E, rs2_E and rd_E, input, REG_AW, meaning execute-stage sources and destination.
REQ-007 SHALL have ports regwrite_E and load_E, input, 1 each, meaning E writes rd and E is a load.
REQ-008 SHALL have ports rd_M and rd_W, input, REG_AW, and regwrite_M and regwrite_W, input, 1, meaning M/W destination and write enable.
REQ-009 SHALL have port pcsrc_E, input, 1, meaning branch taken or jump resolved in E.
REQ-010 SHALL have ports md_start_E and md_done, input, 1 each, meaning multi-cycle op in E and unit completion.
REQ-011 SHALL have outputs stall_F, stall_D, stall_E, flush_D, flush_E and flush_M, 1 each, meaning pipeline-register hold and clear.
REQ-012 SHALL have outputs fwdA_E and fwdB_E, 2 each, meaning E operand forward select.
REQ-013 SHALL have outputs md_req and md_busy, 1 each, meaning start pulse to the multi-cycle unit and sequencer not idle.
REQ-014 SHALL have output stall_cnt, CNT_W, meaning saturating count of stalled cycles.

Function
REQ-015 SHALL drive forward select 2'b10 for the M result when regwrite_M is high, rd_M is nonzero and rd_M equals the E source; otherwise 2'b01 for the W result on the same rule with W; otherwise 2'b00; M SHALL take priority and x0 SHALL never forward.
REQ-016 SHALL detect load-use when load_E is high, rd_E is nonzero and rd_E equals rs1_D or rs2_D; stall_F, stall_D and flush_E SHALL then assert combinationally for exactly that cycle.
REQ-017 SHALL assert flush_D and flush_E when pcsrc_E is high; flush SHALL override load-use stall in the same cycle, with stall_F and stall_D low.
REQ-018 SHALL run a sequencer FSM with states IDLE, REQ and WAIT.
REQ-019 SHALL move IDLE to REQ on md_start_E, REQ to WAIT unconditionally, and WAIT to IDLE on md_done.
REQ-020 SHALL assert md_req only in REQ, for one cycle.
REQ-021 SHALL assert md_busy in REQ and in WAIT.
REQ-022 SHALL assert stall_F, stall_D, stall_E and flush_M whenever md_busy is high, or in IDLE with md_start_E high.
REQ-023 SHALL give the busy stall priority over load-use and pcsrc_E; flush_D and flush_E SHALL stay low while busy.
REQ-024 SHALL release the stall in the same cycle md_done is sampled high in WAIT.
REQ-025 SHALL ignore md_done outside WAIT.
REQ-026 SHALL increment stall_cnt each cycle stall_F is high, saturate at all-ones and never wrap.

Reset
REQ-027 SHALL on rst, asynchronously and regardless of clk, set the FSM to IDLE, md_req and md_busy to 0 and stall_cnt to 0.
REQ-028 SHALL abandon an operation on reset mid-WAIT without waiting for md_done.
REQ-029 SHALL, after release, follow REQ-015 to REQ-017 combinationally for all other outputs.

Configuration
REQ-030 SHALL, with HAZARD_FWD_EN defined, implement forwarding per REQ-015.
REQ-031 SHALL, without HAZARD_FWD_EN, tie fwdA_E and fwdB_E to 2'b00, and also treat a RAW match of rs1_D or rs2_D against a nonzero rd_E (with regwrite_E) or rd_M (with regwrite_M) as load-use per REQ-016; W needs no stall because the register file is write-first.

Structure
REQ-032 SHALL place the forward-select encodings (FWD_RF, FWD_W, FWD_M) and the FSM state enum in the shared pipeline package.
REQ-033 SHALL have one sub-module, hazard_md_seq, holding the FSM and stall_cnt; forwarding and load-use logic SHALL stay in the top module.

Verification
REQ-034 SHALL cover: rd_M=5, regwrite_M=1, rd_W=5, regwrite_W=1, rs1_E=5 -> fwdA_E=2'b10; the same with rd_M=0 -> fwdA_E=2'b01.
REQ-035 SHALL cover: load_E=1, rd_E=7, rs2_D=7 -> stall_F=stall_D=flush_E=1 for one cycle; the same with rd_E=0 -> no stall.
REQ-036 SHALL cover: load-use with pcsrc_E=1 in the same cycle -> flush_D=flush_E=1 and stall_F=0.
REQ-037 SHALL cover: md_start_E pulse, md_done 4 cycles after md_req -> md_req high one cycle, stall_F high 6 cycles, then IDLE; stall_cnt=6.
REQ-038 SHALL cover: rst asserted mid-WAIT -> md_busy=0 and stall_cnt=0 immediately, with no clock edge needed.
REQ-039 SHALL cover: CNT_W=4 and 20 stalled cycles -> stall_cnt=15; and HAZARD_FWD_EN undefined with rd_M=3, rs1_D=3 -> stall asserted and fwd=2'b00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: forward-select
// encodings and the multi-cycle sequencer state type.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_REQ  = 2'd1,
      MD_WAIT = 2'd2
   } md_state_e;

endpackage

// File: rtl/hazard_md_seq.sv
// Multi-cycle unit sequencer (IDLE -> REQ -> WAIT) plus the saturating
// stalled-cycle counter.
module hazard_md_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             md_start_i,
   input  logic             md_done_i,
   input  logic             stall_f_i,
   output logic             md_req_o,
   output logic             md_busy_o,
   output logic             md_stall_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and counter registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and busy stall; WAIT releases the stall in the md_done cycle.
   always_comb begin
      state_d    = state_q;
      md_stall_o = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (md_start_i) begin
               state_d    = MD_REQ;
               md_stall_o = 1'b1;
            end else begin
               state_d    = MD_IDLE;
            end
         end
         MD_REQ: begin
            state_d    = MD_WAIT;
            md_stall_o = 1'b1;
         end
         MD_WAIT: begin
            if (md_done_i) begin
               state_d    = MD_IDLE;
            end else begin
               md_stall_o = 1'b1;
            end
         end
         default: begin
            state_d    = MD_IDLE;
            md_stall_o = 1'b0;
         end
      endcase
   end

   // Saturating count of cycles with the fetch stage held.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_f_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign md_req_o    = (state_q == MD_REQ);
   assign md_busy_o   = (state_q != MD_IDLE);
   assign stall_cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/RAW stall, branch flush
// and multi-cycle op stall. Optional forwarding is enabled by HAZARD_FWD_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_D,
   input  logic [REG_AW-1:0] rs2_D,
   input  logic [REG_AW-1:0] rs1_E,
   input  logic [REG_AW-1:0] rs2_E,
   input  logic [REG_AW-1:0] rd_E,
   input  logic              regwrite_E,
   input  logic              load_E,
   input  logic [REG_AW-1:0] rd_M,
   input  logic [REG_AW-1:0] rd_W,
   input  logic              regwrite_M,
   input  logic              regwrite_W,
   input  logic              pcsrc_E,
   input  logic              md_start_E,
   input  logic              md_done,
   output logic              stall_F,
   output logic              stall_D,
   output logic              stall_E,
   output logic              flush_D,
   output logic              flush_E,
   output logic              flush_M,
   output logic [1:0]        fwdA_E,
   output logic [1:0]        fwdB_E,
   output logic              md_req,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

   logic md_stall_s;
   logic raw_s;
   logic load_use_s;

`ifdef HAZARD_FWD_EN
   // M result is newest, so it wins over W; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (regwrite_M && (rd_M != X0) && (rd_M == rs)) begin
         return FWD_M;
      end else if (regwrite_W && (rd_W != X0) && (rd_W == rs)) begin
         return FWD_W;
      end else begin
         return FWD_RF;
      end
   endfunction

   assign fwdA_E = fwd_sel(rs1_E);
   assign fwdB_E = fwd_sel(rs2_E);
   assign raw_s  = 1'b0;
`else
   logic unused_s;

   assign fwdA_E   = FWD_RF;
   assign fwdB_E   = FWD_RF;
   // Without forwarding any E/M producer must stall; W is covered by the write-first register file.
   assign raw_s    = (regwrite_E && (rd_E != X0) && ((rd_E == rs1_D) || (rd_E == rs2_D))) ||
                     (regwrite_M && (rd_M != X0) && ((rd_M == rs1_D) || (rd_M == rs2_D)));
   assign unused_s = ^{rd_W, regwrite_W, rs1_E, rs2_E};
`endif

   assign load_use_s = (load_E && (rd_E != X0) && ((rd_E == rs1_D) || (rd_E == rs2_D))) || raw_s;

   // Control priority: busy stall, then branch flush, then load-use stall.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_M = 1'b0;
      if (md_stall_s) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         flush_M = 1'b1;
      end else if (pcsrc_E) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (load_use_s) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end else begin
         stall_F = 1'b0;
      end
   end

   hazard_md_seq #(
      .CNT_W (CNT_W)
   ) u_md_seq (
      .clk         (clk),
      .rst         (rst),
      .md_start_i  (md_start_E),
      .md_done_i   (md_done),
      .stall_f_i   (stall_F),
      .md_req_o    (md_req),
      .md_busy_o   (md_busy),
      .md_stall_o  (md_stall_s),
      .stall_cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;

   localparam logic [5:0] C_NONE = 6'b000000;  // {sF,sD,sE,fD,fE,fM}
   localparam logic [5:0] C_LU   = 6'b110010;
   localparam logic [5:0] C_BR   = 6'b000110;
   localparam logic [5:0] C_MD   = 6'b111001;

`ifdef HAZARD_FWD_EN
   localparam logic [1:0] E_FWD_M = 2'b10;
   localparam logic [1:0] E_FWD_W = 2'b01;
   localparam logic [5:0] E_RAW   = C_NONE;
`else
   localparam logic [1:0] E_FWD_M = 2'b00;
   localparam logic [1:0] E_FWD_W = 2'b00;
   localparam logic [5:0] E_RAW   = C_LU;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic regwrite_E, load_E, regwrite_M, regwrite_W, pcsrc_E, md_start_E, md_done;
   logic stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, md_req, md_busy;
   logic [1:0] fwdA_E, fwdB_E;
   logic [CW-1:0] stall_cnt;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          exp_cnt = 0;
   logic        last_stall = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
      .regwrite_E(regwrite_E), .load_E(load_E),
      .rd_M(rd_M), .rd_W(rd_W), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
      .pcsrc_E(pcsrc_E), .md_start_E(md_start_E), .md_done(md_done),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
      .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
      .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .md_req(md_req), .md_busy(md_busy),
      .stall_cnt(stall_cnt)
   );

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: observed %0h required an entry", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Push expectations for the current cycle, settle to mid-cycle, then compare.
   task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic req, input logic busy);
      push({tag, ".ctl"},  {26'd0, ctl});
      push({tag, ".fwdA"}, {30'd0, fa});
      push({tag, ".fwdB"}, {30'd0, fb});
      push({tag, ".req"},  {31'd0, req});
      push({tag, ".busy"}, {31'd0, busy});
      push({tag, ".cnt"},  exp_cnt);
      last_stall = ctl[5];
      #4;
      pop_cmp({26'd0, stall_F, stall_D, stall_E, flush_D, flush_E, flush_M});
      pop_cmp({30'd0, fwdA_E});
      pop_cmp({30'd0, fwdB_E});
      pop_cmp({31'd0, md_req});
      pop_cmp({31'd0, md_busy});
      pop_cmp({{(32-CW){1'b0}}, stall_cnt});
   endtask

   task automatic tick();
      @(posedge clk);
      if (last_stall && !rst && exp_cnt != 15) exp_cnt++;
      #1;
   endtask

   task automatic clear_inputs();
      {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
      {regwrite_E, load_E, regwrite_M, regwrite_W, pcsrc_E, md_start_E, md_done} = '0;
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      exp_cnt = 0;
      last_stall = 1'b0;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      step("reset", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      // Forwarding: M beats W; x0 in M falls back to W.
      rd_M = 5'd5; regwrite_M = 1'b1; rd_W = 5'd5; regwrite_W = 1'b1; rs1_E = 5'd5;
      step("fwd_m", C_NONE, E_FWD_M, 2'b00, 1'b0, 1'b0);
      tick();
      rd_M = 5'd0;
      step("fwd_w", C_NONE, E_FWD_W, 2'b00, 1'b0, 1'b0);
      tick();
      rs2_E = 5'd5;
      step("fwd_wb", C_NONE, E_FWD_W, E_FWD_W, 1'b0, 1'b0);
      tick();
      clear_inputs();

      // Load-use on rs2, only for the cycle it is present.
      load_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7;
      step("lu", C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      clear_inputs();
      step("lu_after", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      load_E = 1'b1; rd_E = 5'd0; rs2_D = 5'd0;
      step("lu_x0", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();

      // Branch flush overrides load-use.
      rd_E = 5'd7; rs2_D = 5'd7; pcsrc_E = 1'b1;
      step("lu_br", C_BR, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      clear_inputs();

      // M-stage RAW against decode: stall only without forwarding.
      rd_M = 5'd3; regwrite_M = 1'b1; rs1_D = 5'd3;
      step("raw_m", E_RAW, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      clear_inputs();
      step("raw_after", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();

      // Multi-cycle op: start, REQ, four WAIT cycles, done -> six stalled cycles.
      rst_pulse();
      md_start_E = 1'b1;
      step("md_start", C_MD, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      md_start_E = 1'b0; pcsrc_E = 1'b1; md_done = 1'b1;
      step("md_req", C_MD, 2'b00, 2'b00, 1'b1, 1'b1);
      tick();
      pcsrc_E = 1'b0; md_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step("md_wait", C_MD, 2'b00, 2'b00, 1'b0, 1'b1);
         tick();
      end
      md_done = 1'b1;
      step("md_done", C_NONE, 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      md_done = 1'b0;
      step("md_idle", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      md_done = 1'b1;
      step("md_done_idle", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      md_done = 1'b0;

      // Reset in the middle of WAIT takes effect with no clock edge.
      md_start_E = 1'b1;
      step("md2_start", C_MD, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();
      md_start_E = 1'b0;
      step("md2_req", C_MD, 2'b00, 2'b00, 1'b1, 1'b1);
      tick();
      step("md2_wait", C_MD, 2'b00, 2'b00, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      step("rst_wait", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      step("rst_after", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      tick();

      // Twenty stalled cycles saturate a 4-bit counter at 15.
      rst_pulse();
      load_E = 1'b1; rd_E = 5'd9; rs1_D = 5'd9;
      for (int i = 0; i < 20; i++) begin
         step("sat", C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
         tick();
      end
      clear_inputs();
      step("sat_end", C_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
      push("sat_value", 32'd15);
      pop_cmp({{(32-CW){1'b0}}, stall_cnt});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
